mem_stage: RTL and testbench

Memory-access stage of the five-stage LoongArch pipeline. Accepts instructions from EX over the valid/allowin handshake and receives the synchronous data-SRAM read data one cycle after EX issued the request. Aligns and extends load data, then presents the final register-write value to WB and to the ID forwarding/interlock logic. Holds SRAM read data internally when WB back-pressures, so no load result is lost.

---
 rtl/mem_stage_pkg.sv | 24 ++
 rtl/mem_stage_load_align.sv | 41 ++++
 rtl/mem_stage.sv | 106 ++++++++++
 tb/tb_mem_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the LoongArch MEM stage: load-op encodings,
// fixed ISA widths and the registered instruction payload.
package mem_stage_pkg;

  localparam int DATA_W = 32;
  localparam int RF_AW  = 5;

  typedef enum logic [2:0] {
    MEM_OP_LW  = 3'b000,
    MEM_OP_LB  = 3'b001,
    MEM_OP_LH  = 3'b010,
    MEM_OP_LBU = 3'b101,
    MEM_OP_LHU = 3'b110
  } mem_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic              res_from_mem;
    logic              rf_we;
    logic [RF_AW-1:0]  rf_waddr;
    logic [DATA_W-1:0] alu_result;
  } ms_payload_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load alignment/extension (LB/LH/LBU/LHU/LW).
// Only built when MEM_LOAD_EXT_EN is defined; otherwise MEM passes raw data through.
`ifdef MEM_LOAD_EXT_EN
module load_align
  import mem_stage_pkg::*;
(
  input  logic [DATA_W-1:0] i_raw,
  input  logic [1:0]        i_addr,
  input  mem_op_e           i_mem_op,
  output logic [DATA_W-1:0] o_aligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    w_byte = i_raw[7:0];
    case (i_addr)
      2'd1:    w_byte = i_raw[15:8];
      2'd2:    w_byte = i_raw[23:16];
      2'd3:    w_byte = i_raw[31:24];
      default: w_byte = i_raw[7:0];
    endcase
    // Halfword selection ignores addr[0]; misalignment is not trapped here.
    w_half = i_addr[1] ? i_raw[31:16] : i_raw[15:0];
  end

  always_comb begin
    o_aligned = i_raw;
    case (i_mem_op)
      MEM_OP_LB:  o_aligned = {{24{w_byte[7]}}, w_byte};
      MEM_OP_LBU: o_aligned = {24'd0, w_byte};
      MEM_OP_LH:  o_aligned = {{16{w_half[15]}}, w_half};
      MEM_OP_LHU: o_aligned = {16'd0, w_half};
      default:    o_aligned = i_raw;
    endcase
  end

endmodule
`endif

// File: rtl/mem_stage.sv
// LoongArch MEM stage: EX->MEM handshake, SRAM read-data hold buffer for WB stalls,
// load alignment. Optional feature macro: MEM_LOAD_EXT_EN (byte/halfword loads).
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              es_to_ms_valid,
  output logic              ms_allowin,
  input  logic [DATA_W-1:0] es_pc,
  input  logic              es_res_from_mem,
  input  logic [2:0]        es_mem_op,
  input  logic              es_rf_we,
  input  logic [RF_AW-1:0]  es_rf_waddr,
  input  logic [DATA_W-1:0] es_alu_result,
  input  logic [DATA_W-1:0] data_sram_rdata,
  input  logic              ws_allowin,
  output logic              ms_to_ws_valid,
  output logic [DATA_W-1:0] ms_pc,
  output logic              ms_rf_we,
  output logic [RF_AW-1:0]  ms_rf_waddr,
  output logic [DATA_W-1:0] ms_rf_wdata
);

  logic              r_valid;
  logic              r_first;
  logic              r_hold_vld;
  logic [DATA_W-1:0] r_hold_data;
  ms_payload_t       r_pl;

  logic              w_accept;
  logic              w_capture;
  logic [DATA_W-1:0] w_raw;
  logic [DATA_W-1:0] w_aligned;

  // MEM always completes in one cycle, so only WB back-pressure can block it.
  assign ms_allowin = !r_valid || ws_allowin;
  assign w_accept   = ms_allowin && es_to_ms_valid;
  assign w_capture  = r_valid && r_first && r_pl.res_from_mem && !ws_allowin;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_first <= 1'b0;
    end else begin
      if (ms_allowin) r_valid <= es_to_ms_valid;
      r_first <= w_accept;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pl <= '0;
    end else if (w_accept) begin
      r_pl <= '{pc:           es_pc,
                res_from_mem: es_res_from_mem,
                rf_we:        es_rf_we,
                rf_waddr:     es_rf_waddr,
                alu_result:   es_alu_result};
    end
  end

  // NOTE: hold_data is qualified by hold_vld, but it is reset too so outputs never carry X after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_vld  <= 1'b0;
      r_hold_data <= '0;
    end else if (w_accept) begin
      r_hold_vld  <= 1'b0;
    end else if (w_capture) begin
      r_hold_vld  <= 1'b1;
      r_hold_data <= data_sram_rdata;
    end
  end

  // SRAM data is only valid in the first MEM cycle; afterwards the captured copy is used.
  assign w_raw = r_hold_vld ? r_hold_data : data_sram_rdata;

`ifdef MEM_LOAD_EXT_EN
  mem_op_e r_mem_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_mem_op <= MEM_OP_LW;
    else if (w_accept) r_mem_op <= mem_op_e'(es_mem_op);
  end

  load_align u_load_align (
    .i_raw     (w_raw),
    .i_addr    (r_pl.alu_result[1:0]),
    .i_mem_op  (r_mem_op),
    .o_aligned (w_aligned)
  );
`else
  logic w_unused_mem_op;
  assign w_unused_mem_op = ^es_mem_op;
  assign w_aligned       = w_raw;
`endif

  assign ms_to_ws_valid = r_valid;
  assign ms_pc          = r_pl.pc;
  assign ms_rf_we       = r_valid && r_pl.rf_we;
  assign ms_rf_waddr    = r_pl.rf_waddr;
  assign ms_rf_wdata    = r_pl.res_from_mem ? w_aligned : r_pl.alu_result;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_mem_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic        ld;
    logic [2:0]  op;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] alu;
    logic [31:0] data;
  } instr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        es_to_ms_valid = 1'b0;
  logic        ws_allowin = 1'b1;
  logic [31:0] data_sram_rdata = 32'd0;
  instr_t      drv = '0;

  logic        ms_allowin, ms_to_ws_valid, ms_rf_we;
  logic [31:0] ms_pc, ms_rf_wdata;
  logic [4:0]  ms_rf_waddr;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;
  bit use_junk = 1'b0;

  // Model: the one instruction in MEM, the true SRAM word for it, and cycles spent in MEM.
  bit     m_valid = 1'b0;
  instr_t m_cur = '0;
  int     m_age = 0;

  logic [2:0] ops [5] = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b110};

  always #5 clk = ~clk;

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .es_to_ms_valid  (es_to_ms_valid),
    .ms_allowin      (ms_allowin),
    .es_pc           (drv.pc),
    .es_res_from_mem (drv.ld),
    .es_mem_op       (drv.op),
    .es_rf_we        (drv.we),
    .es_rf_waddr     (drv.wa),
    .es_alu_result   (drv.alu),
    .data_sram_rdata (data_sram_rdata),
    .ws_allowin      (ws_allowin),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_pc           (ms_pc),
    .ms_rf_we        (ms_rf_we),
    .ms_rf_waddr     (ms_rf_waddr),
    .ms_rf_wdata     (ms_rf_wdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_wdata(input instr_t t);
    logic [31:0] sh;
    int a;
    if (!t.ld) return t.alu;
`ifdef MEM_LOAD_EXT_EN
    a = int'(t.alu[1:0]);
    case (t.op)
      3'b001:  begin sh = t.data >> (8 * a);        return {{24{sh[7]}}, sh[7:0]}; end
      3'b101:  begin sh = t.data >> (8 * a);        return {24'd0, sh[7:0]}; end
      3'b010:  begin sh = t.data >> (16 * (a / 2)); return {{16{sh[15]}}, sh[15:0]}; end
      3'b110:  begin sh = t.data >> (16 * (a / 2)); return {16'd0, sh[15:0]}; end
      default: return t.data;
    endcase
`else
    a = 0;
    sh = t.data;
    return sh;
`endif
  endfunction

  function automatic instr_t mk(input logic ld, input logic [2:0] op, input logic [31:0] alu,
                                input logic [31:0] data, input logic [4:0] wa);
    instr_t t;
    t.pc = 32'h1c00_0000 + alu; t.ld = ld; t.op = op; t.we = 1'b1;
    t.wa = wa; t.alu = alu; t.data = data;
    return t;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 1'b0;
      m_age   = 0;
    end else if (!m_valid || ws_allowin) begin
      if (es_to_ms_valid) begin
        m_valid = 1'b1;
        m_cur   = drv;
        m_age   = 0;
      end else begin
        m_valid = 1'b0;
      end
    end else begin
      m_age++;
    end
  end

  // The SRAM answers only in the instruction's first MEM cycle; later cycles carry junk.
  always @(posedge clk) begin
    #1;
    if (m_valid && m_age == 0) data_sram_rdata = m_cur.data;
    else if (use_junk)         data_sram_rdata = 32'hDEAD_BEEF;
    else                       data_sram_rdata = $urandom;
  end

  always @(negedge clk) begin
    if (!reset && cmp_en) begin
      check("allowin", {31'd0, ms_allowin}, {31'd0, (!m_valid || ws_allowin)});
      check("to_ws_valid", {31'd0, ms_to_ws_valid}, {31'd0, m_valid});
      if (m_valid) begin
        check("pc", ms_pc, m_cur.pc);
        check("rf_we", {31'd0, ms_rf_we}, {31'd0, m_cur.we});
        check("rf_waddr", {27'd0, ms_rf_waddr}, {27'd0, m_cur.wa});
        check("rf_wdata", ms_rf_wdata, exp_wdata(m_cur));
      end else begin
        check("rf_we_idle", {31'd0, ms_rf_we}, 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input instr_t t);
    drv = t;
    es_to_ms_valid = 1'b1;
    step();
    es_to_ms_valid = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_allowin", {31'd0, ms_allowin}, 32'd1);
    check("rst_valid", {31'd0, ms_to_ws_valid}, 32'd0);
    check("rst_rf_we", {31'd0, ms_rf_we}, 32'd0);
    check("rst_pc", ms_pc, 32'd0);
    check("rst_waddr", {27'd0, ms_rf_waddr}, 32'd0);
    check("rst_wdata", ms_rf_wdata, 32'd0);
    reset = 1'b0;
    cmp_en = 1'b1;
    step();

    issue(mk(1'b0, 3'b000, 32'h0000_1000, 32'd0, 5'd5));
    @(negedge clk);
    check("alu_valid", {31'd0, ms_to_ws_valid}, 32'd1);
    check("alu_wdata", ms_rf_wdata, 32'h0000_1000);
    check("alu_waddr", {27'd0, ms_rf_waddr}, 32'd5);
    step();

    issue(mk(1'b1, 3'b001, 32'h0000_2003, 32'h8000_0000, 5'd6));
    @(negedge clk);
`ifdef MEM_LOAD_EXT_EN
    check("lb_sign", ms_rf_wdata, 32'hFFFF_FF80);
`else
    check("lb_raw", ms_rf_wdata, 32'h8000_0000);
`endif
    step();

    issue(mk(1'b1, 3'b101, 32'h0000_2003, 32'h8000_0000, 5'd7));
    @(negedge clk);
`ifdef MEM_LOAD_EXT_EN
    check("lbu_zero", ms_rf_wdata, 32'h0000_0080);
`else
    check("lbu_raw", ms_rf_wdata, 32'h8000_0000);
`endif
    step();

    issue(mk(1'b1, 3'b110, 32'h0000_2002, 32'hBEEF_1234, 5'd8));
    @(negedge clk);
`ifdef MEM_LOAD_EXT_EN
    check("lhu_hi", ms_rf_wdata, 32'h0000_BEEF);
`else
    check("lhu_raw", ms_rf_wdata, 32'hBEEF_1234);
`endif
    step();

    // Three stalled cycles with the SRAM bus changing underneath the held load.
    ws_allowin = 1'b1;
    issue(mk(1'b1, 3'b000, 32'h0000_3000, 32'h1234_5678, 5'd9));
    ws_allowin = 1'b0;
    use_junk = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_wdata", ms_rf_wdata, 32'h1234_5678);
      check("stall_allowin", {31'd0, ms_allowin}, 32'd0);
      step();
    end
    ws_allowin = 1'b1;
    @(negedge clk);
    check("stall_release", ms_rf_wdata, 32'h1234_5678);
    check("stall_rel_valid", {31'd0, ms_to_ws_valid}, 32'd1);
    step();

    // Asynchronous reset in the middle of a held stall.
    issue(mk(1'b1, 3'b000, 32'h0000_3004, 32'h55AA_55AA, 5'd10));
    ws_allowin = 1'b0;
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_valid", {31'd0, ms_to_ws_valid}, 32'd0);
    check("rst_mid_rf_we", {31'd0, ms_rf_we}, 32'd0);
    check("rst_mid_allowin", {31'd0, ms_allowin}, 32'd1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    use_junk = 1'b0;
    ws_allowin = 1'b1;
    step();
    issue(mk(1'b1, 3'b000, 32'h0000_3008, 32'h0000_CAFE, 5'd11));
    @(negedge clk);
    check("post_rst_lw", ms_rf_wdata, 32'h0000_CAFE);
    step();

    for (int i = 0; i < 3000; i++) begin
      es_to_ms_valid = ($urandom_range(0, 9) < 7);
      ws_allowin     = ($urandom_range(0, 9) < 6);
      drv.pc   = $urandom;
      drv.ld   = 1'($urandom_range(0, 1));
      drv.op   = ops[$urandom_range(0, 4)];
      drv.we   = 1'($urandom_range(0, 1));
      drv.wa   = 5'($urandom_range(0, 31));
      drv.alu  = $urandom;
      drv.data = $urandom;
      step();
    end

    es_to_ms_valid = 1'b0;
    ws_allowin = 1'b1;
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
